mem_arbiter: RTL and testbench

Two-master arbiter for the single-port on-chip RAM (`wram`, 128 x 16, registered address, one-cycle read latency). It sits between the `proc` bus (master 0) and a second bus master such as a DMA/loader engine (master 1), and issues at most one memory access per clock. Arbitration is round-robin, with an optional bounded lock that lets a master hold the RAM for a burst without starving the other master.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the single-port wram, with a bounded lock
// that lets one master burst while the other waits at most BURST_MAX grants.
module mem_arbiter #(
  parameter int AW        = 7,
  parameter int DW        = 16,
  parameter int BURST_MAX = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q
);

  localparam int CW = $clog2(BURST_MAX + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    owner;
  logic          last;
  logic [CW-1:0] burst_cnt;
  logic          tag_rd;
  logic          tag_id;

  logic          any_gnt;
  logic          pick1;
  logic          below_max;
  logic          sel_we;
  logic          sel_lock;
  logic          same_owner;

  assign below_max = (burst_cnt < CW'(BURST_MAX));

  // Lock only breaks ties; a lone requester always wins regardless of owner.
  always_comb begin
    any_gnt = 1'b0;
    pick1   = 1'b0;
    if (m0_req && m1_req) begin
      any_gnt = 1'b1;
      if (owner == OWN0 && m0_lock && below_max)
        pick1 = 1'b0;
      else if (owner == OWN1 && m1_lock && below_max)
        pick1 = 1'b1;
      else
        pick1 = ~last;
    end else if (m0_req) begin
      any_gnt = 1'b1;
    end else if (m1_req) begin
      any_gnt = 1'b1;
      pick1   = 1'b1;
    end
    if (Reset)
      any_gnt = 1'b0;
  end

  always_comb begin
    sel_we     = pick1 ? m1_we   : m0_we;
    sel_lock   = pick1 ? m1_lock : m0_lock;
    same_owner = pick1 ? (owner == OWN1) : (owner == OWN0);
    m0_gnt     = any_gnt & ~pick1;
    m1_gnt     = any_gnt &  pick1;
    mem_addr   = pick1 ? m1_addr  : m0_addr;
    mem_data   = pick1 ? m1_wdata : m0_wdata;
    mem_wren   = any_gnt & sel_we;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      owner     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
      tag_rd    <= 1'b0;
      tag_id    <= 1'b0;
    end else begin
      tag_rd <= any_gnt & ~sel_we;
      tag_id <= pick1;
      if (any_gnt) begin
        last  <= pick1;
        owner <= sel_lock ? (pick1 ? OWN1 : OWN0) : IDLE;
        if (same_owner) begin
          if (burst_cnt != CW'(BURST_MAX))
            burst_cnt <= burst_cnt + CW'(1);
        end else begin
          burst_cnt <= CW'(1);
        end
      end else begin
        owner     <= IDLE;
        burst_cnt <= '0;
      end
    end
  end

  // Reset in the cycle after a read grant drops the pending rvalid.
  assign m0_rvalid = tag_rd & ~tag_id & ~Reset;
  assign m1_rvalid = tag_rd &  tag_id & ~Reset;
  assign m0_rdata  = mem_q;
  assign m1_rdata  = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared against a grant-history reference model and a shadow memory.
module tb_mem_arbiter;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int BM = 4;

  logic          Clock;
  logic          Reset;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  mem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
    .Clock(Clock), .Reset(Reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RAM behaviour: registered address, one-cycle read latency.
  logic [DW-1:0] ram [128];
  always @(posedge Clock) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  typedef struct {int m; bit lk;} hent_t;
  hent_t         hist[$];
  logic [DW-1:0] shadow [128];
  bit            pend_v;
  int            pend_m;
  logic [DW-1:0] pend_d;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            obs_g;
  logic          obs_rv0, obs_rv1;
  logic [DW-1:0] obs_rd0, obs_rd1;
  int            gseq[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_last();
    for (int i = hist.size() - 1; i >= 0; i--)
      if (hist[i].m >= 0) return hist[i].m;
    return 1;
  endfunction

  // Length of the newest grant's run, chained through locked predecessors.
  function automatic int model_streak();
    int x;
    int n;
    if (hist.size() == 0 || hist[hist.size()-1].m < 0) return 0;
    x = hist[hist.size()-1].m;
    n = 1;
    for (int i = hist.size() - 2; i >= 0 && n < BM; i--) begin
      if (hist[i].m == x && hist[i].lk) n++;
      else break;
    end
    return n;
  endfunction

  function automatic int model_grant();
    int h;
    bit hlk;
    if (Reset) return -1;
    if (m0_req && m1_req) begin
      if (hist.size() > 0) begin
        h   = hist[hist.size()-1].m;
        hlk = hist[hist.size()-1].lk;
        if (h >= 0 && hlk && (h == 0 ? m0_lock : m1_lock) && model_streak() < BM)
          return h;
      end
      return 1 - model_last();
    end
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  task automatic step();
    int            g;
    logic          we_s, lk_s;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    g    = model_grant();
    we_s = (g == 1) ? m1_we    : m0_we;
    lk_s = (g == 1) ? m1_lock  : m0_lock;
    a    = (g == 1) ? m1_addr  : m0_addr;
    d    = (g == 1) ? m1_wdata : m0_wdata;
    #3;
    obs_g   = (m0_gnt && m1_gnt) ? 2 : m0_gnt ? 0 : m1_gnt ? 1 : -1;
    obs_rv0 = m0_rvalid;
    obs_rv1 = m1_rvalid;
    obs_rd0 = m0_rdata;
    obs_rd1 = m1_rdata;
    chk("m0_gnt", m0_gnt, g == 0);
    chk("m1_gnt", m1_gnt, g == 1);
    if (g >= 0) begin
      chk("mem_wren", mem_wren, we_s);
      chk("mem_addr", mem_addr, a);
      if (we_s) chk("mem_data", mem_data, d);
    end else begin
      chk("mem_wren_idle", mem_wren, 1'b0);
      if (!Reset) chk("mem_addr_idle", mem_addr, m0_addr);
    end
    chk("m0_rvalid", m0_rvalid, pend_v && !Reset && pend_m == 0);
    chk("m1_rvalid", m1_rvalid, pend_v && !Reset && pend_m == 1);
    if (pend_v && !Reset)
      chk("rdata", (pend_m == 0) ? m0_rdata : m1_rdata, pend_d);
    @(posedge Clock);
    #1;
    pend_v = 1'b0;
    if (Reset) begin
      hist.delete();
    end else begin
      hist.push_back('{g, lk_s});
      if (g >= 0) begin
        if (we_s) shadow[a] = d;
        else begin
          pend_v = 1'b1;
          pend_m = g;
          pend_d = shadow[a];
        end
      end
    end
  endtask

  task automatic idle_all();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) shadow[i] = '0;
    pend_v = 1'b0;
    pend_m = 0;
    pend_d = '0;
    idle_all();
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    idle_all();

    // m0 write then read-back of address 5.
    m0_req = 1; m0_we = 1; m0_addr = 7'd5; m0_wdata = 16'h1234;
    step();
    chk("t1_wr_gnt", obs_g, 0);
    m0_we = 0;
    step();
    chk("t1_rd_gnt", obs_g, 0);
    idle_all();
    step();
    chk("t1_rv0", obs_rv0, 1'b1);
    chk("t1_rdata", obs_rd0, 16'h1234);
    chk("t1_rv1", obs_rv1, 1'b0);

    // Continuous reads from both masters, no lock: strict alternation.
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 7'd5; m1_addr = 7'd5;
    for (int i = 0; i < 6; i++) begin
      step();
      gseq[i] = obs_g;
    end
    for (int i = 0; i < 6; i++) chk("t2_rr", gseq[i], i % 2);
    idle_all();
    step();
    chk("t2_last_rv1", obs_rv1, 1'b1);

    // m1 locked burst against a waiting m0.
    do_reset();
    m0_req = 1; m1_req = 1; m1_lock = 1; m0_addr = 7'd5; m1_addr = 7'd5;
    for (int i = 0; i < 9; i++) begin
      step();
      gseq[i] = obs_g;
    end
    chk("t3_g0", gseq[0], 0);
    for (int i = 1; i <= 4; i++) chk("t3_burst", gseq[i], 1);
    chk("t3_yield", gseq[5], 0);
    chk("t3_resume", gseq[6], 1);
    idle_all();
    step();

    // m1 alone: three writes then three reads.
    m1_req = 1; m1_we = 1;
    for (int i = 0; i < 3; i++) begin
      m1_addr  = 7'(i + 1);
      m1_wdata = 16'(10 + i);
      step();
      chk("t4_wr_gnt", obs_g, 1);
    end
    m1_we = 0;
    for (int i = 0; i < 3; i++) begin
      m1_addr = 7'(i + 1);
      step();
      if (i > 0) chk("t4_rdata", obs_rd1, 16'(10 + i - 1));
    end
    idle_all();
    step();
    chk("t4_rdata_last", obs_rd1, 16'h000C);
    chk("t4_rv1_last", obs_rv1, 1'b1);

    // Reset right after m0's read grant.
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 7'd5; m1_addr = 7'd2;
    step();
    chk("t5_first", obs_g, 0);
    Reset = 1'b1;
    step();
    chk("t5_rv0_suppressed", obs_rv0, 1'b0);
    chk("t5_gnt_in_reset", obs_g, -1);
    step();
    Reset = 1'b0;
    step();
    chk("t5_after_reset", obs_g, 0);
    step();
    chk("t5_no_stale_rv", obs_rv0, 1'b1);

    // Preload every address so random reads have defined data.
    idle_all();
    m0_req = 1; m0_we = 1;
    for (int i = 0; i < 128; i++) begin
      m0_addr  = 7'(i);
      m0_wdata = 16'($urandom);
      step();
    end

    for (int i = 0; i < 400; i++) begin
      Reset    = ($urandom_range(0, 39) == 0);
      m0_req   = ($urandom_range(0, 3) != 0);
      m1_req   = ($urandom_range(0, 3) != 0);
      m0_we    = ($urandom_range(0, 2) == 0);
      m1_we    = ($urandom_range(0, 2) == 0);
      m0_lock  = ($urandom_range(0, 2) != 0);
      m1_lock  = ($urandom_range(0, 2) != 0);
      m0_addr  = 7'($urandom_range(0, 127));
      m1_addr  = 7'($urandom_range(0, 127));
      m0_wdata = 16'($urandom);
      m1_wdata = 16'($urandom);
      step();
    end
    Reset = 1'b0;
    idle_all();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
